fc_feeder: RTL and testbench
============================

# fc_feeder

Sequencer that drives the input side of the fully-connected accumulate core and collects its result. On a start pulse it clears the core, streams `i_num_node` node/weight pairs from two single-port read memories into the core, counts the returned valid beats, then latches the final 32-bit accumulation and pulses done. It sits between the node/weight BRAMs and the FC core, and is the unit the layer controller triggers once per output neuron.

## Interface
- `IN_DATA_WIDTH`, 8: node, weight and bias width; result width is 4*IN_DATA_WIDTH.
- `MAX_NODE`, 256: maximum vector length.
- `ADDR_WIDTH`, 8: memory address width; must satisfy 2^ADDR_WIDTH >= MAX_NODE.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `i_start` in 1: start pulse; sampled only in IDLE.
- `i_num_node` in ADDR_WIDTH+1: vector length N (0..MAX_NODE); latched on accepted start.
- `i_bias` in IN_DATA_WIDTH: bias operand; latched on accepted start (used only with FC_FEEDER_BIAS_EN).
- `o_node_ce`, `o_wegt_ce` out 1: memory read enables.
- `o_node_addr`, `o_wegt_addr` out ADDR_WIDTH: read address, same value on both.
- `i_node_q`, `i_wegt_q` in IN_DATA_WIDTH: memory read data; valid exactly 1 cycle after ce.
- `o_core_run` out 1: core clear pulse.
- `o_core_valid` out 1: core input valid.
- `o_core_node`, `o_core_wegt` out IN_DATA_WIDTH: core operands.
- `i_core_valid` in 1: core output valid (1-cycle delayed echo of `o_core_valid`).
- `i_core_result` in 4*IN_DATA_WIDTH: core running accumulation.
- `o_idle` out 1: high in IDLE.
- `o_done` out 1: 1-cycle pulse when `o_result` updates.
- `o_result` out 4*IN_DATA_WIDTH: latched final accumulation; held until next done.

## Operation
- FSM states: IDLE, RUN, FEED, DRAIN, DONE. Encoding is binary, registered.
- IDLE: `o_idle`=1. If `i_start`=1, latch N and bias, then go to RUN.
- RUN (1 cycle): `o_core_run`=1, clearing the core accumulator. Then:
  - go to FEED if the total beat count B > 0;
  - go to DONE if B = 0, with `o_result` loaded as 0.
  - B = N, or N+1 with bias enabled.
- FEED: issue `ce`=1 with address k = 0..N-1, one per cycle, no gaps. After the last address, go to DRAIN.
- `o_core_valid` is `ce` delayed by one register. `o_core_node`/`o_core_wegt` pass `i_node_q`/`i_wegt_q` through combinationally.
- DRAIN: count `i_core_valid` beats. When the count reaches B, latch `i_core_result` into `o_result` on that edge, then go to DONE.
- DONE (1 cycle): `o_done`=1, then return to IDLE.
- `i_start` outside IDLE is ignored, including in DONE.
- Return-beat counting runs from FEED onward, so beats returning during FEED are counted.
- Counters are ADDR_WIDTH+1 bits. The address counter wraps only through a reset at RUN; addresses are never ≥ N.
- `i_num_node` > MAX_NODE is clamped to MAX_NODE.
- A `reset` assertion at any point forces IDLE within the same cycle. All outputs go to 0 and `o_result` is cleared. No done pulse occurs.

## Timing
- Reset values are 0 for all outputs, except `o_idle`=1.
- Start accepted at edge 0.
  - RUN is cycle 1.
  - First `ce` is cycle 2; last `ce` is cycle N+1.
  - Core valid is cycles 3..N+2; core echo is cycles 4..N+3.
  - `o_result` is latched at the end of cycle N+3; `o_done` is high in cycle N+4.
- Start-to-done latency is N+4 cycles, or N+5 with bias. With N=0 it is 2 cycles.
- Back-to-back: the earliest next start is accepted in the IDLE cycle following DONE.

## Configuration
- `FC_FEEDER_BIAS_EN` defined:
  - after the last memory beat, FEED adds one extra beat with `ce`=0;
  - on that beat, `o_core_node` = latched bias and `o_core_wegt` = 1, with `o_core_valid`=1 one cycle later, aligned like memory beats;
  - B = N+1, so the result includes + bias.
- Not defined: no bias beat, B = N, and `i_bias` is unused and unconnected internally.

## Structure
- Shared package `fc_pkg` holds:
  - the FSM state typedef/localparams (IDLE, RUN, FEED, DRAIN, DONE);
  - the result-width constant (4*IN_DATA_WIDTH);
  - the counter-width derivation function.
- Sub-module `fc_beat_counter`: a loadable up-counter with terminal-count compare. It is instantiated twice, once for issued addresses and once for returned beats.

## Test plan
- N=4, node {1,2,3,4}, weight {5,6,7,8} → `o_result`=70. `o_done` in cycle 8 after start, one `o_core_run` pulse, addresses 0..3 contiguous.
- N=3, all 255×255 → `o_result`=195075. No truncation in 32 bits.
- N=0 → `o_done` 2 cycles after start, `o_result`=0, no `ce`.
- With BIAS_EN: N=2, node {2,3}, weight {4,5}, bias=7 → `o_result`=30, done at cycle 7.
- `i_start` asserted during FEED and DONE → ignored. A second start in IDLE after done → new result, and the accumulator is cleared by `o_core_run`.
- `reset` asserted mid-FEED (k=2 of N=8) → immediate IDLE, outputs 0, no `o_done`. A subsequent start gives the correct result.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC feeder: FSM state encoding,
// result width and counter width helpers, bias-beat count (FC_FEEDER_BIAS_EN).
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_t;

    localparam int FC_DEF_IN_WIDTH = 8;
    localparam int FC_RESULT_WIDTH = 4 * FC_DEF_IN_WIDTH;

`ifdef FC_FEEDER_BIAS_EN
    localparam int FC_BIAS_BEATS = 1;
`else
    localparam int FC_BIAS_BEATS = 0;
`endif

    function automatic int fc_res_width(input int in_w);
        return 4 * in_w;
    endfunction

    // One extra bit so a full MAX_NODE count fits.
    function automatic int fc_cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fc_beat_counter.sv
// Loadable up-counter with terminal-count compare.
// Ports: i_load/i_load_val (load), i_inc (count), i_term -> o_tc, o_count.
module fc_beat_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;
    assign o_tc    = (cnt_q == i_term);

endmodule

// File: rtl/fc_feeder.sv
// Sequencer feeding node/weight pairs from BRAMs into the FC accumulate core
// and latching the final sum. Ports: start/num_node/bias in, BRAM ce/addr/q,
// core run/valid/operands out, core valid/result in, idle/done/result out.
// Optional bias beat: FC_FEEDER_BIAS_EN.
module fc_feeder
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int MAX_NODE      = 256,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH:0]        i_num_node,
    input  logic [IN_DATA_WIDTH-1:0]   i_bias,
    output logic                       o_node_ce,
    output logic                       o_wegt_ce,
    output logic [ADDR_WIDTH-1:0]      o_node_addr,
    output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
    input  logic [IN_DATA_WIDTH-1:0]   i_node_q,
    input  logic [IN_DATA_WIDTH-1:0]   i_wegt_q,
    output logic                       o_core_run,
    output logic                       o_core_valid,
    output logic [IN_DATA_WIDTH-1:0]   o_core_node,
    output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
    input  logic                       i_core_valid,
    input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
    output logic                       o_idle,
    output logic                       o_done,
    output logic [4*IN_DATA_WIDTH-1:0] o_result
);

    localparam int CW = fc_cnt_width(ADDR_WIDTH);
    localparam int RW = fc_res_width(IN_DATA_WIDTH);

    fc_state_t state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] last_q, last_d;
    logic [RW-1:0] result_q, result_d;
    logic          valid_q, valid_d;

    logic [CW-1:0] n_clamp;
    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] ret_cnt;
    logic          iss_tc;
    logic          ret_tc;
    logic          in_feed;
    logic          in_drain;
    logic          in_run;
    logic          ce;
    logic          ret_inc;

    assign in_feed  = (state_q == ST_FEED);
    assign in_drain = (state_q == ST_DRAIN);
    assign in_run   = (state_q == ST_RUN);

    assign n_clamp = (i_num_node > CW'(MAX_NODE)) ? CW'(MAX_NODE)
                                                  : i_num_node;

    // Beats past N in FEED are the bias beat: no memory read.
    assign ce      = in_feed && (iss_cnt < n_q);
    assign ret_inc = i_core_valid && (in_feed || in_drain);

    // Both counters compare against the last beat index B-1.
    fc_beat_counter #(.W(CW)) u_iss_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (in_run),
        .i_load_val ('0),
        .i_inc      (in_feed),
        .i_term     (last_q),
        .o_count    (iss_cnt),
        .o_tc       (iss_tc)
    );

    fc_beat_counter #(.W(CW)) u_ret_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (in_run),
        .i_load_val ('0),
        .i_inc      (ret_inc),
        .i_term     (last_q),
        .o_count    (ret_cnt),
        .o_tc       (ret_tc)
    );

`ifdef FC_FEEDER_BIAS_EN
    logic [IN_DATA_WIDTH-1:0] bias_q, bias_d;
    logic                     bsel_q, bsel_d;
`endif

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        last_d   = last_q;
        result_d = result_q;
        valid_d  = in_feed;
`ifdef FC_FEEDER_BIAS_EN
        bias_d   = bias_q;
        bsel_d   = in_feed && !ce;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    n_d    = n_clamp;
                    last_d = n_clamp + CW'(FC_BIAS_BEATS) - CW'(1);
`ifdef FC_FEEDER_BIAS_EN
                    bias_d = i_bias;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((n_q + CW'(FC_BIAS_BEATS)) == '0) begin
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (iss_tc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_core_valid && ret_tc) begin
                    result_d = i_core_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            last_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            last_q   <= last_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FC_FEEDER_BIAS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bias_q <= '0;
            bsel_q <= 1'b0;
        end else begin
            bias_q <= bias_d;
            bsel_q <= bsel_d;
        end
    end

    assign o_core_node = !valid_q ? '0 :
                         bsel_q   ? bias_q : i_node_q;
    assign o_core_wegt = !valid_q ? '0 :
                         bsel_q   ? IN_DATA_WIDTH'(1) : i_wegt_q;
`else
    assign o_core_node = valid_q ? i_node_q : '0;
    assign o_core_wegt = valid_q ? i_wegt_q : '0;
`endif

    assign o_node_ce    = ce;
    assign o_wegt_ce    = ce;
    assign o_node_addr  = ce ? iss_cnt[ADDR_WIDTH-1:0] : '0;
    assign o_wegt_addr  = ce ? iss_cnt[ADDR_WIDTH-1:0] : '0;
    assign o_core_run   = in_run;
    assign o_core_valid = valid_q;
    assign o_idle       = (state_q == ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_result     = result_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Self-checking bench for fc_feeder: BRAM and FC-core models, directed
// and randomized runs checked against a sum-of-products reference.
module tb_fc_feeder;

`ifdef FC_FEEDER_BIAS_EN
    localparam int BIAS_EN = 1;
`else
    localparam int BIAS_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [8:0]  i_num_node;
    logic [7:0]  i_bias;
    logic        o_node_ce, o_wegt_ce;
    logic [7:0]  o_node_addr, o_wegt_addr;
    logic [7:0]  i_node_q, i_wegt_q;
    logic        o_core_run, o_core_valid;
    logic [7:0]  o_core_node, o_core_wegt;
    logic        i_core_valid;
    logic [31:0] i_core_result;
    logic        o_idle, o_done;
    logic [31:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] node_mem [256];
    logic [7:0] wegt_mem [256];

    always #5 clk = ~clk;

    fc_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_num_node    (i_num_node),
        .i_bias        (i_bias),
        .o_node_ce     (o_node_ce),
        .o_wegt_ce     (o_wegt_ce),
        .o_node_addr   (o_node_addr),
        .o_wegt_addr   (o_wegt_addr),
        .i_node_q      (i_node_q),
        .i_wegt_q      (i_wegt_q),
        .o_core_run    (o_core_run),
        .o_core_valid  (o_core_valid),
        .o_core_node   (o_core_node),
        .o_core_wegt   (o_core_wegt),
        .i_core_valid  (i_core_valid),
        .i_core_result (i_core_result),
        .o_idle        (o_idle),
        .o_done        (o_done),
        .o_result      (o_result)
    );

    // Single-port BRAMs, one cycle read latency.
    always @(posedge clk) begin
        if (o_node_ce) i_node_q <= node_mem[o_node_addr];
        if (o_wegt_ce) i_wegt_q <= wegt_mem[o_wegt_addr];
    end

    // FC core: clear on run, accumulate on valid, echo valid one cycle later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i_core_result <= '0;
            i_core_valid  <= 1'b0;
        end else begin
            i_core_valid <= o_core_valid;
            if (o_core_run)
                i_core_result <= '0;
            else if (o_core_valid)
                i_core_result <= i_core_result
                               + 32'(o_core_node) * 32'(o_core_wegt);
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_rand(input int lo);
        for (int k = 0; k < 256; k++) begin
            node_mem[k] = 8'($urandom_range(lo, 255));
            wegt_mem[k] = 8'($urandom_range(lo, 255));
        end
    endtask

    // One start-to-done operation. poke drives i_start in FEED and DONE.
    task automatic run_op(input string tag, input int n_in, input int bias,
                          input bit poke);
        int     neff;
        longint exp_res;
        int     exp_lat;
        int     cyc;
        int     ce_n;
        int     run_n;
        int     addr_bad;
        int     done_cyc;
        longint res;
        neff     = (n_in > 256) ? 256 : n_in;
        exp_res  = 0;
        for (int k = 0; k < neff; k++)
            exp_res += longint'(node_mem[k]) * longint'(wegt_mem[k]);
        if (BIAS_EN != 0) exp_res += longint'(bias);
        exp_lat  = (neff + BIAS_EN == 0) ? 2 : neff + 4 + BIAS_EN;
        cyc      = 0;
        ce_n     = 0;
        run_n    = 0;
        addr_bad = 0;
        done_cyc = -1;
        res      = 0;
        @(negedge clk);
        i_num_node = 9'(n_in);
        i_bias     = 8'(bias);
        i_start    = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        while (done_cyc < 0 && cyc < neff + 20) begin
            @(negedge clk);
            cyc++;
            if (o_core_run) run_n++;
            if (o_node_ce) begin
                if (o_node_addr != 8'(ce_n) || o_wegt_addr != o_node_addr
                    || !o_wegt_ce)
                    addr_bad++;
                ce_n++;
            end
            if (o_done) begin
                done_cyc = cyc;
                res      = longint'(o_result);
            end
            i_start = poke && (cyc == 3 || o_done);
        end
        check({tag, "_done_lat"}, done_cyc, exp_lat);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_run_pulses"}, run_n, 1);
        check({tag, "_ce_count"}, ce_n, neff);
        check({tag, "_addr_bad"}, addr_bad, 0);
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, o_idle, 1);
        check({tag, "_no_restart"}, o_core_run, 0);
        check({tag, "_done_1cyc"}, o_done, 0);
        check({tag, "_result_held"}, longint'(o_result), exp_res);
    endtask

    task automatic reset_mid_feed();
        int cyc;
        int late_done;
        cyc       = 0;
        late_done = 0;
        @(negedge clk);
        i_num_node = 9'd8;
        i_start    = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        while (!(o_node_ce && o_node_addr == 8'd2) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_k2", cyc, 4);
        reset = 1'b1;
        #1;
        check("rst_idle", o_idle, 1);
        check("rst_ce", o_node_ce, 0);
        check("rst_valid", o_core_valid, 0);
        check("rst_result", longint'(o_result), 0);
        check("rst_done", o_done, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_done || !o_idle) late_done++;
        end
        check("rst_quiet", late_done, 0);
    endtask

    initial begin
        reset      = 1'b1;
        i_start    = 1'b0;
        i_num_node = '0;
        i_bias     = '0;
        fill_rand(0);
        repeat (3) @(negedge clk);
        check("reset_idle", o_idle, 1);
        check("reset_done", o_done, 0);
        check("reset_result", longint'(o_result), 0);
        check("reset_ce", o_node_ce, 0);
        check("reset_run", o_core_run, 0);
        check("reset_valid", o_core_valid, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            node_mem[k] = 8'(k + 1);
            wegt_mem[k] = 8'(k + 5);
        end
        run_op("n4", 4, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            node_mem[k] = 8'hff;
            wegt_mem[k] = 8'hff;
        end
        run_op("n3_max", 3, 0, 1'b0);

        run_op("n0", 0, 0, 1'b0);

        node_mem[0] = 8'd2;
        node_mem[1] = 8'd3;
        wegt_mem[0] = 8'd4;
        wegt_mem[1] = 8'd5;
        run_op("n2_bias", 2, 7, 1'b0);

        fill_rand(1);
        run_op("poke", 6, 9, 1'b1);
        run_op("b2b", 5, 3, 1'b0);

        reset_mid_feed();
        run_op("post_rst", 8, 11, 1'b0);

        fill_rand(0);
        run_op("clamp", 300, 200, 1'b0);

        for (int i = 0; i < 14; i++) begin
            int n;
            n = $urandom_range(0, 24);
            fill_rand(0);
            run_op("rand", n, $urandom_range(0, 255),
                   (n >= 4) && (i % 3 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
